cnn_tile_sched: RTL and testbench

//  Layer-level scheduler that sequences CNNBuffer over a whole input feature map: row tiles x input channels.
//  Per tile it drives base address, row offset, depth/width, padding edges and buf_refresh; issues req;

---
 rtl/cnn_sched_pkg.sv | 25 ++
 rtl/cnn_tile_addr_gen.sv | 121 ++++++++++++
 rtl/cnn_tile_sched.sv | 198 +++++++++++++++++++
 tb/tb_cnn_tile_sched.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_sched_pkg.sv
// Shared types for the CNN layer tile scheduler: FSM states, padding bit map and the
// per-layer settings the scheduler holds constant while a layer runs.
package cnn_sched_pkg;

    localparam int unsigned PAD_LEFT   = 0;
    localparam int unsigned PAD_RIGHT  = 1;
    localparam int unsigned PAD_TOP    = 2;
    localparam int unsigned PAD_BOTTOM = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONF,
        ST_REQ,
        ST_RUN,
        ST_FINAL,
        ST_DONE
    } sched_state_e;

    typedef struct packed {
        logic [1:0]  pad_lr;       // {right,left}
        logic [1:0]  pad_tb;       // {bottom,top}
        logic [15:0] conf_offset;  // pitch - fm_w - 1
    } layer_desc_t;

endpackage

// File: rtl/cnn_tile_addr_gen.sv
// Tile/channel position counters and row/channel address accumulators for cnn_tile_sched.
// Derives first/last tile flags and the clipped tile depth from the current row position.
module cnn_tile_addr_gen
    import cnn_sched_pkg::*;
#(
    parameter  int unsigned BUF_DEPTH = 16,
    parameter  int unsigned ROW_W     = 12,
    parameter  int unsigned CH_W      = 10,
    localparam int unsigned DEPTH_W   = $clog2(BUF_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               next_tile,
    input  logic               next_ch,
    input  logic [31:0]        cfg_base,
    input  logic [15:0]        cfg_pitch,
    input  logic [31:0]        cfg_ch_stride,
    input  logic [ROW_W-1:0]   cfg_fm_h,
    input  logic [ROW_W-1:0]   cfg_tile_step,
    input  logic [CH_W-1:0]    cfg_num_ch,
    output logic [ROW_W-1:0]   tile_idx,
    output logic [CH_W-1:0]    ch_idx,
    output logic [31:0]        conf_addr,
    output logic [DEPTH_W-1:0] buf_depth,
    output logic               first_tile,
    output logic               last_tile,
    output logic               more_ch
);

    logic [ROW_W-1:0] fm_h_q, fm_h_d;
    logic [ROW_W-1:0] step_q, step_d;
    logic [31:0]      step_bytes_q, step_bytes_d;
    logic [31:0]      ch_stride_q, ch_stride_d;
    logic [CH_W-1:0]  num_ch_q, num_ch_d;
    logic [ROW_W-1:0] row_start_q, row_start_d;
    logic [ROW_W-1:0] tile_q, tile_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [31:0]      ch_base_q, ch_base_d;
    logic [31:0]      row_addr_q, row_addr_d;

    logic [ROW_W:0]   rows_left;
    logic [ROW_W:0]   depth_rows;

    // The only multiply happens once per layer; per-tile updates are pure adds.
    always_comb begin
        fm_h_d       = fm_h_q;
        step_d       = step_q;
        step_bytes_d = step_bytes_q;
        ch_stride_d  = ch_stride_q;
        num_ch_d     = num_ch_q;
        row_start_d  = row_start_q;
        tile_d       = tile_q;
        ch_d         = ch_q;
        ch_base_d    = ch_base_q;
        row_addr_d   = row_addr_q;
        if (start) begin
            fm_h_d       = cfg_fm_h;
            step_d       = cfg_tile_step;
            step_bytes_d = 32'(cfg_tile_step) * 32'(cfg_pitch);
            ch_stride_d  = cfg_ch_stride;
            num_ch_d     = cfg_num_ch;
            row_start_d  = '0;
            tile_d       = '0;
            ch_d         = '0;
            ch_base_d    = cfg_base;
            row_addr_d   = cfg_base;
        end else if (next_tile) begin
            row_start_d  = row_start_q + step_q;
            tile_d       = tile_q + ROW_W'(1);
            row_addr_d   = row_addr_q + step_bytes_q;
        end else if (next_ch) begin
            ch_d         = ch_q + CH_W'(1);
            ch_base_d    = ch_base_q + ch_stride_q;
            row_addr_d   = ch_base_q + ch_stride_q;
            row_start_d  = '0;
            tile_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fm_h_q       <= '0;
            step_q       <= '0;
            step_bytes_q <= '0;
            ch_stride_q  <= '0;
            num_ch_q     <= '0;
            row_start_q  <= '0;
            tile_q       <= '0;
            ch_q         <= '0;
            ch_base_q    <= '0;
            row_addr_q   <= '0;
        end else begin
            fm_h_q       <= fm_h_d;
            step_q       <= step_d;
            step_bytes_q <= step_bytes_d;
            ch_stride_q  <= ch_stride_d;
            num_ch_q     <= num_ch_d;
            row_start_q  <= row_start_d;
            tile_q       <= tile_d;
            ch_q         <= ch_d;
            ch_base_q    <= ch_base_d;
            row_addr_q   <= row_addr_d;
        end
    end

    // One extra bit so the last tile never wraps; zero rows (idle after reset) reports depth 0.
    always_comb begin
        rows_left  = {1'b0, fm_h_q} - {1'b0, row_start_q};
        last_tile  = (rows_left <= (ROW_W+1)'(BUF_DEPTH));
        depth_rows = last_tile ? rows_left : (ROW_W+1)'(BUF_DEPTH);
        buf_depth  = (depth_rows == '0) ? '0 : DEPTH_W'(depth_rows - (ROW_W+1)'(1));
        first_tile = (row_start_q == '0);
        more_ch    = (ch_q < num_ch_q);
    end

    assign tile_idx  = tile_q;
    assign ch_idx    = ch_q;
    assign conf_addr = row_addr_q;

endmodule

// File: rtl/cnn_tile_sched.sv
// Layer-level scheduler driving CNNBuffer over row tiles x input channels.
// Optional CNN_SCHED_PERF_EN adds perf_run_cycles / perf_tiles counters.
module cnn_tile_sched
    import cnn_sched_pkg::*;
#(
    parameter  int unsigned BUF_DEPTH = 16,
    parameter  int unsigned BUF_WIDTH = 64,
    parameter  int unsigned ROW_W     = 12,
    parameter  int unsigned CH_W      = 10,
    localparam int unsigned DEPTH_W   = $clog2(BUF_DEPTH),
    localparam int unsigned WIDTH_W   = $clog2(BUF_WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [31:0]        cfg_base,
    input  logic [ROW_W-1:0]   cfg_fm_h,
    input  logic [WIDTH_W-1:0] cfg_fm_w,
    input  logic [15:0]        cfg_pitch,
    input  logic [31:0]        cfg_ch_stride,
    input  logic [CH_W-1:0]    cfg_num_ch,
    input  logic [ROW_W-1:0]   cfg_tile_step,
    input  logic [1:0]         cfg_pad_lr,
    input  logic [1:0]         cfg_pad_tb,
    input  logic               abort,
    output logic [DEPTH_W-1:0] buf_depth_o,
    output logic [WIDTH_W-1:0] buf_width_o,
    output logic [3:0]         padding_valid_o,
    output logic               buf_refresh_o,
    output logic               conf_addr_valid,
    output logic [31:0]        conf_addr,
    output logic               conf_offset_valid,
    output logic [15:0]        conf_offset,
    output logic               req_o,
    output logic               req_final_o,
    input  logic               window_finish,
    output logic [ROW_W-1:0]   tile_idx,
    output logic [CH_W-1:0]    ch_idx,
    output logic               busy,
    output logic               done
`ifdef CNN_SCHED_PERF_EN
    ,
    output logic [31:0]        perf_run_cycles,
    output logic [15:0]        perf_tiles
`endif
);

    sched_state_e       state_q, state_d;
    logic               abort_q, abort_d;
    layer_desc_t        desc_q, desc_d;
    logic [WIDTH_W-1:0] fm_w_q, fm_w_d;

    logic start, next_tile, next_ch;
    logic first_tile, last_tile, more_ch;

    cnn_tile_addr_gen #(
        .BUF_DEPTH (BUF_DEPTH),
        .ROW_W     (ROW_W),
        .CH_W      (CH_W)
    ) u_addr_gen (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .next_tile     (next_tile),
        .next_ch       (next_ch),
        .cfg_base      (cfg_base),
        .cfg_pitch     (cfg_pitch),
        .cfg_ch_stride (cfg_ch_stride),
        .cfg_fm_h      (cfg_fm_h),
        .cfg_tile_step (cfg_tile_step),
        .cfg_num_ch    (cfg_num_ch),
        .tile_idx      (tile_idx),
        .ch_idx        (ch_idx),
        .conf_addr     (conf_addr),
        .buf_depth     (buf_depth_o),
        .first_tile    (first_tile),
        .last_tile     (last_tile),
        .more_ch       (more_ch)
    );

    always_comb begin
        state_d   = state_q;
        abort_d   = abort_q;
        desc_d    = desc_q;
        fm_w_d    = fm_w_q;
        start     = 1'b0;
        next_tile = 1'b0;
        next_ch   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    start              = 1'b1;
                    abort_d            = 1'b0;
                    desc_d.pad_lr      = cfg_pad_lr;
                    desc_d.pad_tb      = cfg_pad_tb;
                    desc_d.conf_offset = cfg_pitch - 16'(cfg_fm_w) - 16'd1;
                    fm_w_d             = cfg_fm_w;
                    state_d            = ST_CONF;
                end
            end
            ST_CONF:  state_d = abort ? ST_IDLE : ST_REQ;
            ST_REQ:   state_d = abort ? ST_IDLE : ST_RUN;
            ST_RUN: begin
                // Abort outranks window_finish; the tile is still closed with one FINAL.
                if (abort) begin
                    abort_d = 1'b1;
                    state_d = ST_FINAL;
                end else if (window_finish) begin
                    state_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                if (abort_q || abort) begin
                    state_d = ST_DONE;
                end else if (!last_tile) begin
                    next_tile = 1'b1;
                    state_d   = ST_CONF;
                end else if (more_ch) begin
                    next_ch = 1'b1;
                    state_d = ST_CONF;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            abort_q <= 1'b0;
            desc_q  <= '0;
            fm_w_q  <= '0;
        end else begin
            state_q <= state_d;
            abort_q <= abort_d;
            desc_q  <= desc_d;
            fm_w_q  <= fm_w_d;
        end
    end

    always_comb begin
        cfg_ready                   = (state_q == ST_IDLE);
        busy                        = (state_q != ST_IDLE);
        conf_addr_valid             = (state_q == ST_CONF);
        buf_refresh_o               = (state_q == ST_CONF);
        conf_offset_valid           = (state_q == ST_CONF) || (state_q == ST_REQ) ||
                                      (state_q == ST_RUN);
        req_o                       = (state_q == ST_REQ);
        req_final_o                 = (state_q == ST_FINAL);
        done                        = (state_q == ST_DONE);
        conf_offset                 = desc_q.conf_offset;
        buf_width_o                 = fm_w_q;
        padding_valid_o             = '0;
        padding_valid_o[PAD_LEFT]   = desc_q.pad_lr[0];
        padding_valid_o[PAD_RIGHT]  = desc_q.pad_lr[1];
        padding_valid_o[PAD_TOP]    = first_tile & desc_q.pad_tb[0];
        padding_valid_o[PAD_BOTTOM] = last_tile & desc_q.pad_tb[1];
    end

`ifdef CNN_SCHED_PERF_EN
    logic [31:0] perf_run_q, perf_run_d;
    logic [15:0] perf_tiles_q, perf_tiles_d;

    always_comb begin
        perf_run_d   = perf_run_q;
        perf_tiles_d = perf_tiles_q;
        if (start) begin
            perf_run_d   = '0;
            perf_tiles_d = '0;
        end else begin
            if (state_q == ST_RUN && perf_run_q != '1) begin
                perf_run_d = perf_run_q + 32'd1;
            end
            if (state_q == ST_FINAL && perf_tiles_q != '1) begin
                perf_tiles_d = perf_tiles_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_run_q   <= '0;
            perf_tiles_q <= '0;
        end else begin
            perf_run_q   <= perf_run_d;
            perf_tiles_q <= perf_tiles_d;
        end
    end

    assign perf_run_cycles = perf_run_q;
    assign perf_tiles      = perf_tiles_q;
`endif

endmodule

// File: tb/tb_cnn_tile_sched.sv
// Directed, table-driven bench for cnn_tile_sched (perf counters checked when CNN_SCHED_PERF_EN is set).
module tb_cnn_tile_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_base = '0;
    logic [11:0] cfg_fm_h = '0;
    logic [5:0]  cfg_fm_w = '0;
    logic [15:0] cfg_pitch = '0;
    logic [31:0] cfg_ch_stride = '0;
    logic [9:0]  cfg_num_ch = '0;
    logic [11:0] cfg_tile_step = '0;
    logic [1:0]  cfg_pad_lr = '0;
    logic [1:0]  cfg_pad_tb = '0;
    logic        abort = 1'b0;
    logic [3:0]  buf_depth_o;
    logic [5:0]  buf_width_o;
    logic [3:0]  padding_valid_o;
    logic        buf_refresh_o;
    logic        conf_addr_valid;
    logic [31:0] conf_addr;
    logic        conf_offset_valid;
    logic [15:0] conf_offset;
    logic        req_o;
    logic        req_final_o;
    logic        window_finish = 1'b0;
    logic [11:0] tile_idx;
    logic [9:0]  ch_idx;
    logic        busy;
    logic        done;
`ifdef CNN_SCHED_PERF_EN
    logic [31:0] perf_run_cycles;
    logic [15:0] perf_tiles;
`endif

    cnn_tile_sched dut (
        .clk               (clk),
        .rst               (rst),
        .cfg_valid         (cfg_valid),
        .cfg_ready         (cfg_ready),
        .cfg_base          (cfg_base),
        .cfg_fm_h          (cfg_fm_h),
        .cfg_fm_w          (cfg_fm_w),
        .cfg_pitch         (cfg_pitch),
        .cfg_ch_stride     (cfg_ch_stride),
        .cfg_num_ch        (cfg_num_ch),
        .cfg_tile_step     (cfg_tile_step),
        .cfg_pad_lr        (cfg_pad_lr),
        .cfg_pad_tb        (cfg_pad_tb),
        .abort             (abort),
        .buf_depth_o       (buf_depth_o),
        .buf_width_o       (buf_width_o),
        .padding_valid_o   (padding_valid_o),
        .buf_refresh_o     (buf_refresh_o),
        .conf_addr_valid   (conf_addr_valid),
        .conf_addr         (conf_addr),
        .conf_offset_valid (conf_offset_valid),
        .conf_offset       (conf_offset),
        .req_o             (req_o),
        .req_final_o       (req_final_o),
        .window_finish     (window_finish),
        .tile_idx          (tile_idx),
        .ch_idx            (ch_idx),
        .busy              (busy),
        .done              (done)
`ifdef CNN_SCHED_PERF_EN
        ,
        .perf_run_cycles   (perf_run_cycles),
        .perf_tiles        (perf_tiles)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [31:0]       base;
        logic [11:0]       fm_h;
        logic [5:0]        fm_w;
        logic [15:0]       pitch;
        logic [31:0]       ch_stride;
        logic [9:0]        num_ch;
        logic [11:0]       step;
        logic [1:0]        pad_lr;
        logic [1:0]        pad_tb;
        logic [2:0]        n_conf;
        logic [15:0]       off;
        logic [3:0][31:0]  addr;
        logic [3:0][3:0]   depth;
        logic [3:0][3:0]   pad;
        logic [3:0][11:0]  tile;
        logic [3:0][9:0]   ch;
    } vec_t;

    vec_t vecs [5];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_layer(input int i, input logic [31:0] base, input logic [11:0] fm_h,
                             input logic [5:0] fm_w, input logic [15:0] pitch,
                             input logic [31:0] stride, input logic [9:0] num_ch,
                             input logic [11:0] step, input logic [1:0] lr, input logic [1:0] tb,
                             input logic [2:0] n, input logic [15:0] off);
        vecs[i]           = '0;
        vecs[i].base      = base;
        vecs[i].fm_h      = fm_h;
        vecs[i].fm_w      = fm_w;
        vecs[i].pitch     = pitch;
        vecs[i].ch_stride = stride;
        vecs[i].num_ch    = num_ch;
        vecs[i].step      = step;
        vecs[i].pad_lr    = lr;
        vecs[i].pad_tb    = tb;
        vecs[i].n_conf    = n;
        vecs[i].off       = off;
    endtask

    task automatic set_exp(input int i, input int k, input logic [31:0] addr, input logic [3:0] depth,
                           input logic [3:0] pad, input logic [11:0] tile, input logic [9:0] ch);
        vecs[i].addr[k]  = addr;
        vecs[i].depth[k] = depth;
        vecs[i].pad[k]   = pad;
        vecs[i].tile[k]  = tile;
        vecs[i].ch[k]    = ch;
    endtask

    task automatic drive_cfg(input int i);
        cfg_base      = vecs[i].base;
        cfg_fm_h      = vecs[i].fm_h;
        cfg_fm_w      = vecs[i].fm_w;
        cfg_pitch     = vecs[i].pitch;
        cfg_ch_stride = vecs[i].ch_stride;
        cfg_num_ch    = vecs[i].num_ch;
        cfg_tile_step = vecs[i].step;
        cfg_pad_lr    = vecs[i].pad_lr;
        cfg_pad_tb    = vecs[i].pad_tb;
    endtask

    // Runs one layer; window_finish rises after d RUN cycles. abort_tile>=0 aborts that tile's RUN
    // together with window_finish.
    task automatic run_layer(input int i, input int d, input int abort_tile);
        int n_conf = 0, n_req = 0, n_fin = 0, n_done = 0;
        int cnt = 0, fin_cyc = -100, exp_n;
        exp_n = (abort_tile >= 0) ? abort_tile + 1 : int'(vecs[i].n_conf);
        window_finish = 1'b0;
        check($sformatf("v%0d_cfg_ready", i), 128'(cfg_ready), 128'(1));
        drive_cfg(i);
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        for (int cyc = 0; cyc < 2000 && n_done == 0; cyc++) begin
            abort = 1'b0;
            if (conf_addr_valid) begin
                if (n_conf < 4) begin
                    check($sformatf("v%0d_t%0d_addr", i, n_conf), 128'(conf_addr), 128'(vecs[i].addr[n_conf]));
                    check($sformatf("v%0d_t%0d_depth", i, n_conf), 128'(buf_depth_o), 128'(vecs[i].depth[n_conf]));
                    check($sformatf("v%0d_t%0d_pad", i, n_conf), 128'(padding_valid_o), 128'(vecs[i].pad[n_conf]));
                    check($sformatf("v%0d_t%0d_tile", i, n_conf), 128'(tile_idx), 128'(vecs[i].tile[n_conf]));
                    check($sformatf("v%0d_t%0d_ch", i, n_conf), 128'(ch_idx), 128'(vecs[i].ch[n_conf]));
                    check($sformatf("v%0d_t%0d_refresh", i, n_conf), 128'({buf_refresh_o, conf_offset_valid}), 128'(3));
                    check($sformatf("v%0d_t%0d_offset", i, n_conf), 128'(conf_offset), 128'(vecs[i].off));
                    check($sformatf("v%0d_t%0d_width", i, n_conf), 128'(buf_width_o), 128'(vecs[i].fm_w));
                end
                n_conf++;
            end
            if (req_o) begin
                n_req++;
                window_finish = 1'b0;
                cnt = d;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    window_finish = 1'b1;
                    if (abort_tile == n_conf - 1) abort = 1'b1;
                end
            end
            if (req_final_o) begin
                n_fin++;
                fin_cyc = cyc;
            end
            if (done) begin
                n_done++;
                check($sformatf("v%0d_done_latency", i), 128'(cyc - fin_cyc), 128'(1));
            end else begin
                @(negedge clk);
            end
        end
        abort = 1'b0;
        check($sformatf("v%0d_done_seen", i), 128'(n_done), 128'(1));
        check($sformatf("v%0d_conf_count", i), 128'(n_conf), 128'(exp_n));
        check($sformatf("v%0d_req_count", i), 128'(n_req), 128'(exp_n));
        check($sformatf("v%0d_final_count", i), 128'(n_fin), 128'(exp_n));
        @(negedge clk);
        check($sformatf("v%0d_idle_after", i), 128'({cfg_ready, busy, done}), 128'(3'b100));
    endtask

    function automatic logic [127:0] all_outs();
        return 128'({buf_depth_o, buf_width_o, padding_valid_o, buf_refresh_o, conf_addr_valid,
                     conf_addr, conf_offset_valid, conf_offset, req_o, req_final_o,
                     tile_idx, ch_idx, busy, done});
    endfunction

    initial begin
        int seen;
        // base, fm_h, fm_w, pitch, ch_stride, num_ch, step, pad_lr, pad_tb, tiles, offset
        set_layer(0, 32'h2000, 12'd10, 6'd31, 16'd64, 32'h0, 10'd0, 12'd14, 2'b11, 2'b11, 3'd1, 16'd32);
        set_exp(0, 0, 32'h2000, 4'd9, 4'hF, 12'd0, 10'd0);
        set_layer(1, 32'h1000, 12'd40, 6'd63, 16'd64, 32'h0, 10'd0, 12'd14, 2'b01, 2'b11, 3'd3, 16'd0);
        set_exp(1, 0, 32'h1000, 4'd15, 4'h5, 12'd0, 10'd0);
        set_exp(1, 1, 32'h1380, 4'd15, 4'h1, 12'd1, 10'd0);
        set_exp(1, 2, 32'h1700, 4'd11, 4'h9, 12'd2, 10'd0);
        set_layer(2, 32'h1000, 12'd16, 6'd15, 16'd32, 32'h800, 10'd2, 12'd14, 2'b10, 2'b11, 3'd3, 16'd16);
        set_exp(2, 0, 32'h1000, 4'd15, 4'hE, 12'd0, 10'd0);
        set_exp(2, 1, 32'h1800, 4'd15, 4'hE, 12'd0, 10'd1);
        set_exp(2, 2, 32'h2000, 4'd15, 4'hE, 12'd0, 10'd2);
        set_layer(3, 32'hFFFF_FF00, 12'd17, 6'd63, 16'h100, 32'h0, 10'd0, 12'd16, 2'b00, 2'b01, 3'd2, 16'hC0);
        set_exp(3, 0, 32'hFFFF_FF00, 4'd15, 4'h4, 12'd0, 10'd0);
        set_exp(3, 1, 32'h0000_0F00, 4'd0, 4'h0, 12'd1, 10'd0);
        set_layer(4, 32'h40, 12'd1, 6'd7, 16'd8, 32'h100, 10'd1, 12'd1, 2'b11, 2'b10, 3'd2, 16'd0);
        set_exp(4, 0, 32'h40, 4'd0, 4'hB, 12'd0, 10'd0);
        set_exp(4, 1, 32'h140, 4'd0, 4'hB, 12'd0, 10'd1);

        repeat (3) @(negedge clk);
        check("reset_outputs_zero", all_outs(), '0);
        check("reset_cfg_ready", 128'(cfg_ready), 128'(1));
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_layer(i, 2 + i, -1);

        // Abort in RUN of tile 1 (coincident with window_finish): one FINAL, then DONE.
        run_layer(1, 3, 1);

        // Abort in CONF: straight back to IDLE, no req, no done.
        window_finish = 1'b0;
        drive_cfg(1);
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        check("abort_conf_in_conf", 128'(conf_addr_valid), 128'(1));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_conf_idle", 128'({cfg_ready, busy}), 128'(2'b10));
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (req_o || req_final_o || done) seen++;
            @(negedge clk);
        end
        check("abort_conf_quiet", 128'(seen), 128'(0));

        // Reset in RUN, with a stray descriptor offered while busy.
        drive_cfg(1);
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        @(negedge clk);
        check("rst_seq_req", 128'(req_o), 128'(1));
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_base  = 32'hDEAD_0000;
        @(negedge clk);
        cfg_valid = 1'b0;
        check("busy_cfg_ignored", 128'({cfg_ready, busy, conf_addr}), 128'({2'b01, 32'h1000}));
        rst = 1'b0;
        @(negedge clk);
        check("midlayer_rst_zero", all_outs(), '0);
        check("midlayer_rst_ready", 128'(cfg_ready), 128'(1));
        rst = 1'b1;
        @(negedge clk);
        run_layer(1, 2, -1);

`ifdef CNN_SCHED_PERF_EN
        run_layer(1, 50, -1);
        check("perf_run_cycles", 128'(perf_run_cycles), 128'(150));
        check("perf_tiles", 128'(perf_tiles), 128'(3));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
